// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// odd-parity frame out on device clock edges and reports ACK (done) or NACK/timeout (error).
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    inout  wire        ps2_clk,
    inout  wire        ps2_data
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;

    state_t        state, state_nx;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          clk_s, data_s, fall;
    logic [9:0]    frame, frame_nx;
    logic [3:0]    n, n_nx;
    logic [IW-1:0] inh_cnt, inh_nx;
    logic [TW-1:0] to_cnt, to_nx;
    logic          done_nx, error_nx;
    logic          clk_low, data_low;

    assign clk_s = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall = clk_prev & ~clk_s;

    // Not ready during a done/error pulse, so a held request lands one cycle later.
    assign tx_ready = (state == IDLE) && reset && !done && !error;
    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        n_nx = n;
        inh_nx = inh_cnt;
        to_nx = to_cnt;
        frame_nx = frame;
        done_nx = 1'b0;
        error_nx = 1'b0;
        if (state != IDLE) to_nx = to_cnt + TW'(1);
        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_nx = INHIBIT;
                    frame_nx = {1'b1, ~^tx_data, tx_data};
                    n_nx = 4'd0;
                    inh_nx = '0;
                    to_nx = '0;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_LAST) state_nx = REQ;
                else inh_nx = inh_cnt + IW'(1);
            end
            REQ: state_nx = BITS;
            BITS: begin
                if (fall) begin
                    if (n != 4'hF) n_nx = n + 4'd1;
                    if (n_nx == 4'd10) state_nx = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    if (data_s) begin
                        error_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_nx = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Timeout wins over any fall or completion seen in the same cycle.
        if (state != IDLE && to_cnt == TO_LAST) begin
            state_nx = IDLE;
            done_nx = 1'b0;
            error_nx = 1'b1;
        end
    end

    always_comb begin
        clk_low = (state == INHIBIT) || (state == REQ);
        data_low = 1'b0;
        if (state == REQ) begin
            data_low = 1'b1;
        end else if (state == BITS) begin
            if (n == 4'd0) data_low = 1'b1;
            else if (n <= 4'd10) data_low = ~frame[n - 4'd1];
        end
    end

    assign ps2_clk = clk_low ? 1'b0 : 1'bz;
    assign ps2_data = data_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            clk_sync <= 2'b11;
            data_sync <= 2'b11;
            clk_prev <= 1'b1;
            frame <= '0;
            n <= 4'd0;
            inh_cnt <= '0;
            to_cnt <= '0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nx;
            clk_sync <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev <= clk_s;
            frame <= frame_nx;
            n <= n_nx;
            inh_cnt <= inh_nx;
            to_cnt <= to_nx;
            done <= done_nx;
            error <= error_nx;
        end
    end
endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: behavioural PS/2 device on pulled-up open-drain lines,
// per-scenario tasks with hand-computed frames, pulse and bus monitors.
module tb_ps2_tx;
    localparam int INH = 20;
    localparam int TO = 5000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;
    wire        ps2_clk_w, ps2_data_w;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int tests = 0;
    int fails = 0;

    assign ps2_clk_w = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_data_w = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk_w);
    pullup (ps2_data_w);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
        .ps2_clk(ps2_clk_w), .ps2_data(ps2_data_w)
    );

    always #5 clk = ~clk;

    // Monitor: cycle-stamped acceptances and pulses, idle-bus and ready-after-pulse checks.
    int   cyc = 0;
    int   acc_q[$];
    int   done_q[$];
    int   err_q[$];
    logic err_data = 1'b0, err_data_prev = 1'b0, data_prev = 1'b1;
    bit   pulse_prev = 1'b0;
    int   idle_bad = 0, both_hi = 0, rdy_bad = 0;

    always @(posedge clk) begin
        if (tx_valid && tx_ready) acc_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (error) begin
            err_q.push_back(cyc);
            err_data = ps2_data_w;
            err_data_prev = data_prev;
        end
        if (done && error) both_hi++;
        if (pulse_prev && reset && tx_ready !== 1'b1) rdy_bad++;
        if (reset && !busy && !dev_clk_low && !dev_data_low &&
            (ps2_clk_w !== 1'b1 || ps2_data_w !== 1'b1)) idle_bad++;
        pulse_prev = done || error;
        data_prev = ps2_data_w;
        cyc++;
    end

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            tests++; fails++;
            $display("FAIL send_ready: tx_ready stayed %b, expected 1 within 100 cycles", tx_ready);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send, clocks 11 times (40 low / 40 high), samples on rise.
    // got[0] is the start bit seen at request time, got[10:1] the bits read on clocks 1..10.
    task automatic device_xfer(input bit ack, input int abort_at,
                               output logic [10:0] got, output bit to);
        int t = 0;
        got = '0;
        to = 1'b0;
        while (!(ps2_clk_w === 1'b1 && ps2_data_w === 1'b0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            to = 1'b1;
            return;
        end
        got[0] = ps2_data_w;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i == abort_at) return;
            got[i] = ps2_data_w;
            repeat (40) @(negedge clk);
        end
        if (ack) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (40) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, expected 0", tx_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_pulses: done=%b error=%b, expected 0 0", done, error); end
        tests++; if (ps2_clk_w !== 1'b1 || ps2_data_w !== 1'b1) begin fails++; $display("FAIL reset_pins: clk=%b data=%b, expected released (1 1)", ps2_clk_w, ps2_data_w); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b, expected 1", tx_ready); end
    endtask

    task automatic test_send_f4(input string tag);
        int nd, ne, low;
        logic [10:0] got;
        bit to;
        nd = done_q.size();
        ne = err_q.size();
        send(8'hF4);
        low = 0;
        @(negedge clk);
        while (ps2_clk_w === 1'b0 && low < 100) begin
            low++;
            @(negedge clk);
        end
        tests++; if (low !== INH + 1) begin fails++; $display("FAIL %s_inhibit_len: clk low %0d cycles, expected %0d", tag, low, INH + 1); end
        device_xfer(1'b1, 0, got, to);
        // F4: start 0, bits 0,0,1,0,1,1,1,1, parity 0 (five ones), stop 1
        tests++; if (to || got !== 11'h5E8) begin fails++; $display("FAIL %s_frame: got %h (timeout %b), expected 5e8", tag, got, to); end
        tests++; if (done_q.size() - nd !== 1) begin fails++; $display("FAIL %s_done_count: got %0d, expected 1", tag, done_q.size() - nd); end
        tests++; if (err_q.size() - ne !== 0) begin fails++; $display("FAIL %s_error_count: got %0d, expected 0", tag, err_q.size() - ne); end
    endtask

    task automatic test_back_to_back();
        int nd, na, t;
        logic [10:0] got;
        bit to;
        nd = done_q.size();
        na = acc_q.size();
        @(negedge clk);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        t = 0;
        while (acc_q.size() == na && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1 tx_data = 8'hED;
        device_xfer(1'b1, 0, got, to);
        // FF: eight ones -> parity 1
        tests++; if (to || got !== 11'h7FE) begin fails++; $display("FAIL b2b_frame_ff: got %h (timeout %b), expected 7fe", got, to); end
        tx_valid = 1'b0;
        device_xfer(1'b1, 0, got, to);
        // ED = 1110_1101: six ones -> parity 1
        tests++; if (to || got !== 11'h7DA) begin fails++; $display("FAIL b2b_frame_ed: got %h (timeout %b), expected 7da", got, to); end
        tests++; if (done_q.size() - nd !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d, expected 2", done_q.size() - nd); end
        tests++; if (acc_q.size() - na !== 2) begin fails++; $display("FAIL b2b_accept_count: got %0d, expected 2", acc_q.size() - na); end
        if (acc_q.size() - na == 2 && done_q.size() - nd >= 1) begin
            tests++;
            if (acc_q[na + 1] !== done_q[nd] + 1) begin
                fails++;
                $display("FAIL b2b_accept_cycle: accepted at %0d, expected %0d", acc_q[na + 1], done_q[nd] + 1);
            end
        end
    endtask

    task automatic test_nack();
        int nd, ne, rb;
        logic [10:0] got;
        bit to;
        nd = done_q.size();
        ne = err_q.size();
        rb = rdy_bad;
        send(8'hED);
        device_xfer(1'b0, 0, got, to);
        tests++; if (to || got !== 11'h7DA) begin fails++; $display("FAIL nack_frame: got %h (timeout %b), expected 7da", got, to); end
        tests++; if (err_q.size() - ne !== 1) begin fails++; $display("FAIL nack_error_count: got %0d, expected 1", err_q.size() - ne); end
        tests++; if (done_q.size() - nd !== 0) begin fails++; $display("FAIL nack_done_count: got %0d, expected 0", done_q.size() - nd); end
        tests++; if (err_data !== 1'b1) begin fails++; $display("FAIL nack_data_released: got %b, expected 1", err_data); end
        tests++; if (rdy_bad !== rb) begin fails++; $display("FAIL nack_ready_after: %0d cycles with tx_ready low after pulse, expected 0", rdy_bad - rb); end
        tests++; if (ps2_clk_w !== 1'b1 || ps2_data_w !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL nack_idle: clk=%b data=%b busy=%b, expected 1 1 0", ps2_clk_w, ps2_data_w, busy); end
    endtask

    task automatic test_timeout();
        int nd, ne, na, t;
        nd = done_q.size();
        ne = err_q.size();
        na = acc_q.size();
        send(8'hA5);
        t = 0;
        while (err_q.size() == ne && t < TO + 500) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (err_q.size() - ne !== 1) begin
            fails++;
            $display("FAIL timeout_error_count: got %0d, expected 1", err_q.size() - ne);
        end else if (acc_q.size() > na) begin
            // error rises on the TO-th edge after the acceptance edge; stamps are cycles ending at an edge
            if (err_q[ne] - acc_q[na] - 1 !== TO) begin
                fails++;
                $display("FAIL timeout_latency: got %0d edges, expected %0d", err_q[ne] - acc_q[na] - 1, TO);
            end
        end
        tests++; if (err_data !== 1'b1 || err_data_prev !== 1'b0) begin fails++; $display("FAIL timeout_data: before=%b at=%b, expected 0 then 1", err_data_prev, err_data); end
        tests++; if (done_q.size() - nd !== 0) begin fails++; $display("FAIL timeout_done_count: got %0d, expected 0", done_q.size() - nd); end
    endtask

    task automatic test_reset_mid();
        int nd, ne;
        logic [10:0] got;
        bit to;
        nd = done_q.size();
        ne = err_q.size();
        send(8'hF4);
        device_xfer(1'b1, 5, got, to);
        tests++; if (to || busy !== 1'b1) begin fails++; $display("FAIL rmid_busy_before: busy=%b timeout=%b, expected 1 0", busy, to); end
        reset = 1'b0;
        @(negedge clk);
        tests++; if (ps2_clk_w !== 1'b1 || ps2_data_w !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
            fails++; $display("FAIL rmid_after_reset: clk=%b data=%b busy=%b ready=%b, expected 1 1 0 0", ps2_clk_w, ps2_data_w, busy, tx_ready);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (done_q.size() != nd || err_q.size() != ne) begin fails++; $display("FAIL rmid_pulses: done=%0d error=%0d, expected 0 0", done_q.size() - nd, err_q.size() - ne); end
        test_send_f4("rmid_f4");
    endtask

    task automatic test_bus_idle();
        repeat (20) @(negedge clk);
        tests++; if (idle_bad !== 0) begin fails++; $display("FAIL idle_bus: %0d cycles with a line low while idle, expected 0", idle_bad); end
        tests++; if (both_hi !== 0) begin fails++; $display("FAIL done_error_overlap: %0d cycles, expected 0", both_hi); end
        tests++; if (rdy_bad !== 0) begin fails++; $display("FAIL ready_after_pulse: %0d cycles low, expected 0", rdy_bad); end
    endtask

    initial begin
        test_reset();
        test_send_f4("f4");
        test_back_to_back();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_bus_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter. It serialises one command byte (for example 0xFF reset, 0xF4 enable, 0xED LEDs) onto the shared open-drain `ps2_clk`/`ps2_data` lines, then reports whether the device acknowledged it. It sits beside the existing PS/2 receiver in the keyboard path and drives the same two pins.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 12000: cycles `ps2_clk` is held low before the request (120 us at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: maximum cycles from acceptance to completion (20 ms at 100 MHz).

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: reset is synchronous and active-low.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: request. The byte is accepted on a cycle where `tx_valid && tx_ready`.
- `tx_ready` input/output: output 1. High only in IDLE while `reset`=1.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the device ACKed and the bus has returned to idle.
- `error` output 1: one-cycle pulse on NACK or timeout.
- `ps2_clk` inout 1: open-drain. Drives 0 or Z, never 1.
- `ps2_data` inout 1: open-drain. Drives 0 or Z, never 1.

## Operation
Input conditioning:
- Each pin is passed through a 2-flop synchronizer, giving `clk_s` and `data_s`.
- A third flop on `clk_s` detects falling edges: `fall = prev & ~clk_s`.
- There is no glitch filter.

Frame latching at acceptance:
- Latch `frame = {1'b1 stop, parity, tx_data}` with odd parity, `parity = ~^tx_data`.
- Clear the bit counter `n` to 0 and the timeout counter to 0.

States:
- **IDLE**
  - Both lines are released.
  - On acceptance, go to INHIBIT.
- **INHIBIT**
  - `ps2_clk` is driven low; `ps2_data` is released.
  - After `INHIBIT_CYCLES` cycles in this state, go to REQ.
- **REQ** (exactly 1 cycle)
  - `ps2_clk` and `ps2_data` are both driven low.
  - Next state is BITS.
- **BITS**
  - `ps2_clk` is released; `ps2_data` is held low (start bit).
  - On each `fall`, increment `n`, then act on the new value of `n`:
    - `n` = 1..8: drive `ps2_data` from `tx_data[n-1]`, LSB first. A 0 bit is driven low; a 1 bit is released.
    - `n` = 9: drive the parity bit the same way.
    - `n` = 10: release `ps2_data` (stop bit) and go to ACK.
- **ACK**
  - On the next `fall`, sample `data_s`.
  - If 0, go to WAIT_IDLE.
  - If 1, pulse `error` and go to IDLE.
- **WAIT_IDLE**
  - When `clk_s`=1 and `data_s`=1 in the same cycle, pulse `done` and go to IDLE.

Timeout:
- The counter runs in every non-IDLE state.
- When it reaches `TIMEOUT_CYCLES`, pulse `error`, release both lines and go to IDLE.
- Timeout takes priority over a `fall` or a completion in the same cycle.

Arithmetic and widths:
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Inhibit counter width is `$clog2(INHIBIT_CYCLES+1)`.
- `n` is 4 bits and saturates; it never wraps.

Boundary conditions:
- `tx_valid` while busy is ignored. The byte is not accepted and there is no pulse.
- `tx_valid` in the same cycle as `done` or `error` is not accepted, because `tx_ready` is still low. It is accepted the next cycle.
- `done` and `error` are never high together.
- The block does not filter what the shared receiver sees during a transfer. The consumer gates the receiver using `busy`.

## Timing
Reset values (at and after any edge with `reset`=0):
- State is IDLE.
- `tx_ready`=0 while `reset`=0, and 1 on the first cycle after release.
- `busy`=0, `done`=0, `error`=0.
- Both pins are Z.
- Counters are 0.

Reset mid-transfer:
- The lines are released at the reset edge.
- There is no `done` or `error` pulse.

Latencies:
- Acceptance edge to `ps2_clk` low: 1 cycle.
- `ps2_clk` low stays for exactly `INHIBIT_CYCLES` cycles, plus the 1 REQ cycle.
- Pin falling edge to new `ps2_data` value: 3 cycles (2 synchronizer flops plus the edge flop).
- `done`/`error` are registered and assert 1 cycle after the deciding condition. The state returns to IDLE on that same edge, so `tx_ready` is 1 in the cycle after the pulse.

## Test plan
Bench settings: `INHIBIT_CYCLES`=20, `TIMEOUT_CYCLES`=5000. The device model clocks at an 80-cycle period (40 low / 40 high) and samples on rising edges.

- **Send 0xF4, device ACKs** -> `ps2_clk` low for 21 cycles. The device reads start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1. `done` pulses once; `error` stays 0.
- **Send 0xFF, then 0xED back-to-back with `tx_valid` held** -> parity 1 for both bytes. 0xED is accepted only in the cycle after the first `done`. Two `done` pulses in total.
- **Device leaves data high on the 11th clock (NACK)** -> `error` pulses once, no `done`, both lines Z, `tx_ready`=1 the next cycle.
- **Device never clocks** -> `error` pulses exactly 5000 cycles after acceptance. `ps2_data` is released in the same cycle.
- **`reset`=0 for 1 cycle after the 5th falling edge** -> both pins are Z on the next edge, with no `done`/`error`. A subsequent 0xF4 completes normally.
- **Bus idle check** -> both pins are Z and `busy`=0 in every cycle outside a transfer.
